planificador_sqrt: RTL and testbench



---
 rtl/planificador_sqrt_if.sv | 41 ++++
 rtl/planificador_sqrt.sv | 161 ++++++++++++++++
 tb/tb_planificador_sqrt.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/planificador_sqrt_if.sv
`default_nettype none
// ============================================================================
// Module      : planificador_sqrt_if
// Description : Request, engine and result bundle of the sqrt scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface planificador_sqrt_if #(
    parameter int NCH   = 4,
    parameter int W_IN  = 128,
    parameter int W_OUT = 64
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]       req_valid;
    logic [NCH*W_IN-1:0]  req_data;
    logic                 sqrt_start;
    logic [W_IN-1:0]      sqrt_radical;
    logic                 sqrt_done;
    logic [W_OUT-1:0]     sqrt_q;
    logic                 res_valid;
    logic [CW-1:0]        res_chan;
    logic [W_OUT-1:0]     res_data;
    logic [NCH*W_OUT-1:0] amplitude;
    logic [NCH-1:0]       overrun;
    logic                 timeout_err;
    logic                 clear_err;
    logic                 busy;

    modport slave (
        input  req_valid, req_data, sqrt_done, sqrt_q, clear_err,
        output sqrt_start, sqrt_radical, res_valid, res_chan, res_data,
               amplitude, overrun, timeout_err, busy
    );

    modport master (
        output req_valid, req_data, sqrt_done, sqrt_q, clear_err,
        input  sqrt_start, sqrt_radical, res_valid, res_chan, res_data,
               amplitude, overrun, timeout_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/planificador_sqrt.sv
`default_nettype none
// ============================================================================
// Module      : planificador_sqrt
// Description : Round-robin scheduler sharing one multi-cycle sqrt engine.
// Revision    : 1.0 - initial release
// ============================================================================
module planificador_sqrt #(
    parameter int NCH     = 4,
    parameter int W_IN    = 128,
    parameter int W_OUT   = 64,
    parameter int TIMEOUT = 255
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    planificador_sqrt_if.slave   bus
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t               state_q;
    logic [W_IN-1:0]      data_buf_q [NCH];
    logic [NCH-1:0]       pend_q, pend_d;
    logic [NCH-1:0]       overrun_q, overrun_d;
    logic [NCH-1:0]       ovr_set, gnt_vec;
    logic [CW-1:0]        ptr_q, gnt_q, gnt_idx;
    logic                 gnt_found;
    logic [TW-1:0]        timer_q;
    logic                 start_q, res_valid_q, tout_q, busy_q;
    logic [W_IN-1:0]      radical_q;
    logic [CW-1:0]        res_chan_q;
    logic [W_OUT-1:0]     res_data_q;
    logic [NCH*W_OUT-1:0] amp_q;

    function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NCH) s = s - NCH;
        return CW'(s);
    endfunction

    // First pending channel at or after ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!gnt_found && pend_q[wrap_add(ptr_q, i)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_add(ptr_q, i);
            end
        end
    end

    always_comb begin
        gnt_vec = '0;
        if (state_q == S_IDLE && gnt_found) gnt_vec[gnt_idx] = 1'b1;
        // A fresh request re-arms pend even when the old value is granted now.
        pend_d    = bus.req_valid | (pend_q & ~gnt_vec);
        ovr_set   = bus.req_valid & pend_q & ~gnt_vec;
        overrun_d = (bus.clear_err ? '0 : overrun_q) | ovr_set;
    end

    generate
        for (genvar k = 0; k < NCH; k++) begin : g_buf
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    data_buf_q[k] <= '0;
                end else if (bus.req_valid[k]) begin
                    data_buf_q[k] <= bus.req_data[k*W_IN +: W_IN];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q    <= '0;
            overrun_q <= '0;
        end else begin
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            timer_q     <= '0;
            start_q     <= 1'b0;
            radical_q   <= '0;
            res_valid_q <= 1'b0;
            res_chan_q  <= '0;
            res_data_q  <= '0;
            amp_q       <= '0;
            tout_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
            if (bus.clear_err) tout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_found) begin
                        gnt_q     <= gnt_idx;
                        radical_q <= data_buf_q[gnt_idx];
                        start_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_ISSUE;
                    end else begin
                        busy_q    <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.sqrt_done) begin
                        amp_q[int'(gnt_q)*W_OUT +: W_OUT] <= bus.sqrt_q;
                        res_data_q  <= bus.sqrt_q;
                        res_chan_q  <= gnt_q;
                        res_valid_q <= 1'b1;
                        state_q     <= S_WRITE;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        // Engine hung: abandon this value and move on.
                        tout_q  <= 1'b1;
                        ptr_q   <= wrap_add(gnt_q, 1);
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    ptr_q   <= wrap_add(gnt_q, 1);
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sqrt_start   = start_q;
    assign bus.sqrt_radical = radical_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_chan     = res_chan_q;
    assign bus.res_data     = res_data_q;
    assign bus.amplitude    = amp_q;
    assign bus.overrun      = overrun_q;
    assign bus.timeout_err  = tout_q;
    assign bus.busy         = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_planificador_sqrt.sv
`default_nettype none
// ============================================================================
// Module      : tb_planificador_sqrt
// Description : Directed self-checking bench for planificador_sqrt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_planificador_sqrt;
    localparam int NCH     = 4;
    localparam int W_IN    = 128;
    localparam int W_OUT   = 64;
    localparam int TIMEOUT = 255;
    localparam int L       = 5;

    logic clk = 1'b0;
    logic reset_n;
    logic eng_en;
    int   eng_cnt;
    logic eng_busy;
    logic [W_IN-1:0] eng_rad;
    int   cyc;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    planificador_sqrt_if #(.NCH(NCH), .W_IN(W_IN), .W_OUT(W_OUT)) bus ();

    planificador_sqrt #(.NCH(NCH), .W_IN(W_IN), .W_OUT(W_OUT), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    function automatic logic [W_OUT-1:0] isqrt(input logic [W_IN-1:0] x);
        logic [W_IN-1:0] op, res, one;
        op  = x;
        res = '0;
        one = {2'b01, {(W_IN-2){1'b0}}};
        while (one > op) one = one >> 2;
        while (one != 0) begin
            if (op >= res + one) begin
                op  = op - (res + one);
                res = (res >> 1) + one;
            end else begin
                res = res >> 1;
            end
            one = one >> 2;
        end
        return res[W_OUT-1:0];
    endfunction

    // Engine with fixed latency L: start seen in cycle 2 -> done in cycle 2+L.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.sqrt_done <= 1'b0;
            bus.sqrt_q    <= '0;
            eng_cnt       <= 0;
            eng_busy      <= 1'b0;
            eng_rad       <= '0;
        end else begin
            bus.sqrt_done <= 1'b0;
            if (bus.sqrt_start) begin
                eng_busy <= 1'b1;
                eng_cnt  <= L - 1;
                eng_rad  <= bus.sqrt_radical;
            end else if (eng_busy) begin
                if (eng_cnt == 1) begin
                    eng_busy <= 1'b0;
                    if (eng_en) begin
                        bus.sqrt_done <= 1'b1;
                        bus.sqrt_q    <= isqrt(eng_rad);
                    end
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [W_IN-1:0] obs, input logic [W_IN-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.clear_err = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        cyc = 0;
    endtask

    task automatic req(input int k, input logic [W_IN-1:0] v);
        bus.req_valid[k]             = 1'b1;
        bus.req_data[k*W_IN +: W_IN] = v;
    endtask

    task automatic wait_res(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            tick();
            if (bus.res_valid) ok = 1'b1;
        end
    endtask

    function automatic logic [W_OUT-1:0] amp(input int k);
        return bus.amplitude[k*W_OUT +: W_OUT];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, observed timeout, expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int rv;
        logic [W_OUT-1:0] exp_rr [4];
        exp_rr = '{64'd1, 64'd2, 64'd3, 64'd4};
        eng_en       = 1'b1;
        bus.req_data = '0;
        cyc          = 0;

        // Reset state
        do_reset();
        check("rst_busy", bus.busy, 0);
        check("rst_start", bus.sqrt_start, 0);
        check("rst_amp", bus.amplitude, 0);
        check("rst_err", {bus.overrun, bus.timeout_err, bus.res_valid}, 0);

        // Single request, exact latency
        req(1, 144);
        tick(); bus.req_valid = '0;
        check("t1_busy_c1", bus.busy, 0);
        tick();
        check("t1_start_c2", bus.sqrt_start, 1);
        check("t1_radical", bus.sqrt_radical, 144);
        repeat (5) tick();
        check("t1_noval_c7", bus.res_valid, 0);
        tick();
        check("t1_val_c8", bus.res_valid, 1);
        check("t1_chan", bus.res_chan, 1);
        check("t1_data", bus.res_data, 12);
        check("t1_amp1", amp(1), 12);
        check("t1_amp0", amp(0), 0);
        tick();
        check("t1_busy_c9", bus.busy, 0);
        check("t1_val_c9", bus.res_valid, 0);

        // Round robin, all four together
        do_reset();
        req(0, 1); req(1, 4); req(2, 9); req(3, 16);
        tick(); bus.req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            wait_res(40, ok);
            check("rr_seen", ok, 1);
            check("rr_chan", bus.res_chan, i);
            check("rr_data", bus.res_data, exp_rr[i]);
            check("rr_cycle", cyc, 8 * (i + 1));
        end

        // Fairness: ch0 re-requests after its grant, ch2 once
        do_reset();
        req(0, 4);
        tick(); bus.req_valid = '0;
        tick(); req(0, 9);
        tick(); bus.req_valid = '0; req(2, 25);
        tick(); bus.req_valid = '0;
        wait_res(40, ok);
        check("fair_c0", bus.res_chan, 0);
        check("fair_d0", bus.res_data, 2);
        wait_res(40, ok);
        check("fair_c2", bus.res_chan, 2);
        check("fair_d2", bus.res_data, 5);
        wait_res(40, ok);
        check("fair_c0b", bus.res_chan, 0);
        check("fair_d0b", bus.res_data, 3);
        check("fair_ovr", bus.overrun, 0);

        // Overrun on ch3 while busy on ch0, then clear
        do_reset();
        req(0, 100);
        tick(); bus.req_valid = '0;
        tick(); tick(); req(3, 25);
        tick(); req(3, 49);
        tick(); bus.req_valid = '0;
        check("ovr_set", bus.overrun, 4'b1000);
        wait_res(40, ok);
        check("ovr_c0", bus.res_data, 10);
        wait_res(40, ok);
        check("ovr_chan3", bus.res_chan, 3);
        check("ovr_d3", bus.res_data, 7);
        check("ovr_sticky", bus.overrun, 4'b1000);
        bus.clear_err = 1'b1;
        tick(); bus.clear_err = 1'b0;
        check("ovr_clear", bus.overrun, 0);

        // Same-cycle grant and request on ch0
        do_reset();
        req(0, 36);
        tick(); req(0, 64);
        tick(); bus.req_valid = '0;
        check("same_radical", bus.sqrt_radical, 36);
        wait_res(40, ok);
        check("same_d1", bus.res_data, 6);
        check("same_cyc1", cyc, 8);
        wait_res(40, ok);
        check("same_c2", bus.res_chan, 0);
        check("same_d2", bus.res_data, 8);
        check("same_cyc2", cyc, 16);
        check("same_ovr", bus.overrun, 0);
        tick();

        // Timeout: engine silent; ptr is 1 here, ch1 then ch2
        eng_en = 1'b0;
        cyc    = 0;
        rv     = 0;
        req(1, 81); req(2, 4);
        tick(); bus.req_valid = '0;
        while (cyc < 257) begin
            tick();
            if (bus.res_valid) rv++;
        end
        check("to_not_yet", bus.timeout_err, 0);
        tick();
        check("to_set", bus.timeout_err, 1);
        check("to_idle", bus.busy, 0);
        tick();
        if (bus.res_valid) rv++;
        check("to_next_start", bus.sqrt_start, 1);
        check("to_next_rad", bus.sqrt_radical, 4);
        check("to_no_result", rv, 0);
        bus.clear_err = 1'b1;
        tick(); bus.clear_err = 1'b0;
        check("to_clear", bus.timeout_err, 0);

        // Asynchronous reset mid-WAIT
        repeat (3) tick();
        check("pre_rst_amp0", amp(0), 8);
        check("pre_rst_busy", bus.busy, 1);
        reset_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_radical", bus.sqrt_radical, 0);
        check("arst_amp", bus.amplitude, 0);
        check("arst_misc", {bus.res_valid, bus.res_chan, bus.sqrt_start, bus.timeout_err}, 0);
        eng_en = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rv = 0;
        repeat (20) begin
            tick();
            if (bus.res_valid) rv++;
        end
        check("arst_no_res", rv, 0);
        check("arst_idle", bus.busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
